// File: rtl/uart_recv_b8.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_recv_b8
// Purpose  : 8N1 UART receiver that collects eight consecutive bytes into a
//            64-bit word (byte k at bits [8k+7:8k]). A partial word is
//            dropped after TIMEOUT_BITS idle bit-times, and a bad stop bit
//            restarts assembly at slot 0.
// Ports    : sys_clk, sys_rst_n (async, active-low)
//            uart_rxd      serial input, idle high
//            uart_dout     last complete 64-bit word
//            uart_done     1-cycle pulse when uart_dout updates
//            rx_byte       last accepted byte
//            rx_byte_done  1-cycle pulse when rx_byte updates
//            rx_cnt        bytes collected in the current word (0..7)
//            rx_busy       bit receiver outside IDLE
//            frame_err     1-cycle pulse on a low stop bit
//            rx_timeout    1-cycle pulse when a partial word is discarded
// Revision : 1.0 - initial release
// ============================================================================
module uart_recv_b8 #(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int UART_BPS     = 9600,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        uart_rxd,
  output logic [63:0] uart_dout,
  output logic        uart_done,
  output logic [7:0]  rx_byte,
  output logic        rx_byte_done,
  output logic [3:0]  rx_cnt,
  output logic        rx_busy,
  output logic        frame_err,
  output logic        rx_timeout
);

  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int BW      = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
  localparam int TMO_LIM = TIMEOUT_BITS * BPS_CNT;
  localparam int TW      = $clog2(TMO_LIM + 1);

  localparam logic [BW-1:0] BIT_LAST = BW'(BPS_CNT - 1);
  localparam logic [BW-1:0] BIT_MID  = BW'(BPS_CNT / 2);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_LIM - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state, next_state;
  logic            rxd_s1, rxd_s2, rxd_prev;
  logic [BW-1:0]   bit_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic [63:0]     asm_buf;
  logic [TW-1:0]   idle_cnt;

  logic            start_edge, bit_mid, bit_last;
  logic            stop_smp, accept, bad_stop, idle_run, tmo_hit;

  // Synchronizer flops reset low: a line that is already low when reset is
  // released looks like "was low", so no falling edge can be seen until the
  // line has first gone high.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rxd_s1   <= 1'b0;
      rxd_s2   <= 1'b0;
      rxd_prev <= 1'b0;
    end else begin
      rxd_s1   <= uart_rxd;
      rxd_s2   <= rxd_s1;
      rxd_prev <= rxd_s2;
    end
  end

  assign start_edge = (state == IDLE) && rxd_prev && !rxd_s2;
  assign bit_mid    = (bit_cnt == BIT_MID);
  assign bit_last   = (bit_cnt == BIT_LAST);
  assign stop_smp   = (state == STOP) && bit_mid;
  assign accept     = stop_smp && rxd_s2;
  assign bad_stop   = stop_smp && !rxd_s2;
  assign idle_run   = (state == IDLE) && (rx_cnt != 4'd0);
  assign tmo_hit    = idle_run && (idle_cnt == TMO_LAST);
  assign rx_busy    = (state != IDLE);

  // FSM state register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= next_state;
  end

  // FSM next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (start_edge) next_state = START;
      START: begin
        if (bit_mid && rxd_s2) next_state = IDLE;   // false start
        else if (bit_last)     next_state = DATA;
      end
      DATA:  if (bit_last && (bit_idx == 3'd7)) next_state = STOP;
      STOP:  if (bit_mid) next_state = IDLE;          // leave early for back-to-back frames
      default: next_state = IDLE;
    endcase
  end

  // Bit timing and data shift register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bit_cnt <= '0;
      bit_idx <= 3'd0;
      shift   <= 8'd0;
    end else begin
      if (state == IDLE || next_state == IDLE) bit_cnt <= '0;
      else if (bit_last)                       bit_cnt <= '0;
      else                                     bit_cnt <= bit_cnt + 1'b1;

      if (state != DATA)  bit_idx <= 3'd0;
      else if (bit_last)  bit_idx <= bit_idx + 3'd1;

      if (state == DATA && bit_mid) shift <= {rxd_s2, shift[7:1]};
    end
  end

  // Idle counter: only runs while a partial word is waiting in IDLE; a start
  // edge restarts it unless expiry happens in that very cycle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                             idle_cnt <= '0;
    else if (idle_run && !start_edge && !tmo_hit) idle_cnt <= idle_cnt + 1'b1;
    else                                        idle_cnt <= '0;
  end

  // Byte acceptance, word assembly and status pulses. Accept/frame error
  // happen only in STOP and timeout only in IDLE, so they are exclusive.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      asm_buf      <= 64'd0;
      uart_dout    <= 64'd0;
      uart_done    <= 1'b0;
      rx_byte      <= 8'd0;
      rx_byte_done <= 1'b0;
      rx_cnt       <= 4'd0;
      frame_err    <= 1'b0;
      rx_timeout   <= 1'b0;
    end else begin
      uart_done    <= 1'b0;
      rx_byte_done <= 1'b0;
      frame_err    <= 1'b0;
      rx_timeout   <= 1'b0;
      if (accept) begin
        rx_byte      <= shift;
        rx_byte_done <= 1'b1;
        asm_buf[{rx_cnt[2:0], 3'b000} +: 8] <= shift;
        if (rx_cnt == 4'd7) begin
          uart_dout <= {shift, asm_buf[55:0]};
          uart_done <= 1'b1;
          rx_cnt    <= 4'd0;
        end else begin
          rx_cnt <= rx_cnt + 4'd1;
        end
      end else if (bad_stop) begin
        frame_err <= 1'b1;
        rx_cnt    <= 4'd0;
      end else if (tmo_hit) begin
        rx_timeout <= 1'b1;
        rx_cnt     <= 4'd0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_recv_b8.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_recv_b8
// Purpose  : Self-checking bench for uart_recv_b8 with CLK_FREQ=1000,
//            UART_BPS=100 (10 clocks per bit), TIMEOUT_BITS=20 (200 clocks).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_recv_b8;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        uart_rxd = 1'b1;
  logic [63:0] uart_dout;
  logic        uart_done;
  logic [7:0]  rx_byte;
  logic        rx_byte_done;
  logic [3:0]  rx_cnt;
  logic        rx_busy;
  logic        frame_err;
  logic        rx_timeout;

  uart_recv_b8 #(
    .CLK_FREQ    (1000),
    .UART_BPS    (100),
    .TIMEOUT_BITS(20)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .uart_rxd    (uart_rxd),
    .uart_dout   (uart_dout),
    .uart_done   (uart_done),
    .rx_byte     (rx_byte),
    .rx_byte_done(rx_byte_done),
    .rx_cnt      (rx_cnt),
    .rx_busy     (rx_busy),
    .frame_err   (frame_err),
    .rx_timeout  (rx_timeout)
  );

  always #5 sys_clk = ~sys_clk;

  // Pulse monitors, sampled on the falling edge
  int n_bd = 0, n_done = 0, n_fe = 0, n_to = 0, n_busy = 0, n_excl = 0;
  always @(negedge sys_clk) begin
    if (rx_byte_done) n_bd++;
    if (uart_done)    n_done++;
    if (frame_err)    n_fe++;
    if (rx_timeout)   n_to++;
    if (rx_busy)      n_busy++;
    if ((int'(uart_done) + int'(frame_err) + int'(rx_timeout)) > 1) n_excl++;
  end

  int checks = 0, passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Assumes entry just after a rising edge; leaves just after the rising
  // edge that ends the stop bit, so calls chain with no gap.
  task automatic send_byte(input logic [7:0] d, input logic stop);
    uart_rxd = 1'b0;
    repeat (10) @(posedge sys_clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      uart_rxd = d[i];
      repeat (10) @(posedge sys_clk);
      #1;
    end
    uart_rxd = stop;
    repeat (10) @(posedge sys_clk);
    #1;
  endtask

  task automatic send_word(input logic [63:0] w);
    for (int i = 0; i < 8; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic idle_clks(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  typedef struct {
    logic [7:0]  data;
    logic        stop;
    logic [7:0]  exp_byte;
    logic [3:0]  exp_cnt;
    int          d_bd;
    int          d_done;
    int          d_fe;
    logic [63:0] exp_dout;
  } vec_t;

  vec_t tv[11];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int bd0, done0, fe0, to0, busy0;

    // Back-to-back word 01..08, two more good bytes, then a bad stop bit
    for (int i = 0; i < 8; i++) begin
      tv[i].data     = 8'(i + 1);
      tv[i].stop     = 1'b1;
      tv[i].exp_byte = 8'(i + 1);
      tv[i].exp_cnt  = (i == 7) ? 4'd0 : 4'(i + 1);
      tv[i].d_bd     = 1;
      tv[i].d_done   = (i == 7) ? 1 : 0;
      tv[i].d_fe     = 0;
      tv[i].exp_dout = (i == 7) ? 64'h0807060504030201 : 64'd0;
    end
    tv[8]  = '{8'h21, 1'b1, 8'h21, 4'd1, 1, 0, 0, 64'h0807060504030201};
    tv[9]  = '{8'h22, 1'b1, 8'h22, 4'd2, 1, 0, 0, 64'h0807060504030201};
    tv[10] = '{8'h55, 1'b0, 8'h22, 4'd0, 0, 0, 1, 64'h0807060504030201};

    // Reset state
    #23;
    chk("reset_dout", uart_dout, 64'd0);
    chk("reset_rx_byte", {56'd0, rx_byte}, 64'd0);
    chk("reset_rx_cnt", {60'd0, rx_cnt}, 64'd0);
    chk("reset_busy", {63'd0, rx_busy}, 64'd0);
    #10 sys_rst_n = 1'b1;
    idle_clks(20);

    // Table-driven byte stream
    for (int i = 0; i < 11; i++) begin
      bd0 = n_bd; done0 = n_done; fe0 = n_fe;
      send_byte(tv[i].data, tv[i].stop);
      chk($sformatf("v%0d_rx_byte", i), {56'd0, rx_byte}, {56'd0, tv[i].exp_byte});
      chk($sformatf("v%0d_rx_cnt", i), {60'd0, rx_cnt}, {60'd0, tv[i].exp_cnt});
      chk($sformatf("v%0d_byte_pulses", i), 64'(n_bd - bd0), 64'(tv[i].d_bd));
      chk($sformatf("v%0d_done_pulses", i), 64'(n_done - done0), 64'(tv[i].d_done));
      chk($sformatf("v%0d_ferr_pulses", i), 64'(n_fe - fe0), 64'(tv[i].d_fe));
      chk($sformatf("v%0d_dout", i), uart_dout, tv[i].exp_dout);
    end
    uart_rxd = 1'b1;
    idle_clks(20);

    // False start: 3-clock low glitch while a partial word is pending
    send_byte(8'h31, 1'b1);
    send_byte(8'h32, 1'b1);
    bd0 = n_bd; done0 = n_done; fe0 = n_fe; to0 = n_to;
    uart_rxd = 1'b0;
    idle_clks(3);
    uart_rxd = 1'b1;
    idle_clks(30);
    chk("glitch_rx_cnt", {60'd0, rx_cnt}, 64'd2);
    chk("glitch_busy", {63'd0, rx_busy}, 64'd0);
    chk("glitch_pulses", 64'((n_bd - bd0) + (n_done - done0) + (n_fe - fe0) + (n_to - to0)), 64'd0);

    // Timeout: 3 bytes pending, then idle
    send_byte(8'h33, 1'b1);
    to0 = n_to;
    idle_clks(150);
    chk("tmo_early_pulses", 64'(n_to - to0), 64'd0);
    chk("tmo_early_rx_cnt", {60'd0, rx_cnt}, 64'd3);
    idle_clks(55);
    chk("tmo_pulses", 64'(n_to - to0), 64'd1);
    chk("tmo_rx_cnt", {60'd0, rx_cnt}, 64'd0);
    done0 = n_done;
    send_word(64'hA7A6A5A4A3A2A1A0);
    chk("tmo_word_dout", uart_dout, 64'hA7A6A5A4A3A2A1A0);
    chk("tmo_word_done", 64'(n_done - done0), 64'd1);

    // Reset during the data bits of byte 4
    send_byte(8'hC1, 1'b1);
    send_byte(8'hC2, 1'b1);
    send_byte(8'hC3, 1'b1);
    uart_rxd = 1'b0;
    idle_clks(10);
    for (int i = 0; i < 3; i++) begin
      uart_rxd = 1'(8'hC4 >> i);
      idle_clks(10);
    end
    chk("pre_rst_busy", {63'd0, rx_busy}, 64'd1);
    #3 sys_rst_n = 1'b0;
    #1;
    chk("rst_dout", uart_dout, 64'd0);
    chk("rst_rx_byte", {56'd0, rx_byte}, 64'd0);
    chk("rst_rx_cnt", {60'd0, rx_cnt}, 64'd0);
    chk("rst_busy", {63'd0, rx_busy}, 64'd0);
    chk("rst_pulses", {60'd0, uart_done, rx_byte_done, frame_err, rx_timeout}, 64'd0);
    uart_rxd = 1'b1;
    #22 sys_rst_n = 1'b1;
    idle_clks(20);
    done0 = n_done;
    send_word(64'h1716151413121110);
    chk("post_rst_dout", uart_dout, 64'h1716151413121110);
    chk("post_rst_done", 64'(n_done - done0), 64'd1);
    chk("post_rst_rx_cnt", {60'd0, rx_cnt}, 64'd0);

    // Line held low across reset release, then released high
    uart_rxd = 1'b0;
    #2 sys_rst_n = 1'b0;
    #33 sys_rst_n = 1'b1;
    bd0 = n_bd; done0 = n_done; fe0 = n_fe; to0 = n_to; busy0 = n_busy;
    idle_clks(30);
    uart_rxd = 1'b1;
    idle_clks(30);
    chk("lowrst_busy_cycles", 64'(n_busy - busy0), 64'd0);
    chk("lowrst_pulses", 64'((n_bd - bd0) + (n_done - done0) + (n_fe - fe0) + (n_to - to0)), 64'd0);
    chk("lowrst_rx_cnt", {60'd0, rx_cnt}, 64'd0);
    send_byte(8'h5A, 1'b1);
    chk("lowrst_first_byte", {56'd0, rx_byte}, 64'h5A);
    chk("lowrst_first_cnt", {60'd0, rx_cnt}, 64'd1);

    chk("exclusive_pulses", 64'(n_excl), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
